move_sequencer: RTL and testbench
=================================

# move_sequencer

Serialises player actions into the game core's strobe protocol. Parallel move requests (row, col, value) and new-game requests (difficulty) enter on valid/ready handshakes. The block replays them to the game core as `in_new_game` pulses and `in_enter`-qualified 2-bit fields on `in_diff_cell_val`. It sits between the user front-end (keypad or bench driver) and the Sudoku top module, and replaces hand-built enter/value sequences.

## Interface
- DEPTH, 2, move FIFO entries (≥1).
- GAP_CYCLES, 1, idle cycles (enter low) after every enter pulse and after the new-game pulse (≥1).
- in_clka  input  1  sole clock, rising edge.
- in_restart  input  1  asynchronous, active-high reset.
- in_abort  input  1  synchronous flush: empty FIFO, return to IDLE.
- in_core_ready  input  1  core is able to take a new transaction; sampled only in IDLE.
- in_move_valid  input  1  move request valid.
- in_move_row  input  2  row 0-3.
- in_move_col  input  2  column 0-3.
- in_move_val  input  2  cell value code.
- out_move_ready  output  1  move accepted on an edge where valid&ready.
- in_game_valid  input  1  new-game request valid.
- in_game_diff  input  2  difficulty code.
- out_game_ready  output  1  game accepted on an edge where valid&ready.
- out_new_game  output  1  to core in_new_game.
- out_enter  output  1  to core in_enter.
- out_diff_cell_val  output  2  to core in_diff_cell_val.
- out_fifo_count  output  clog2(DEPTH+1)  moves queued (excludes the one being sent).
- out_busy  output  1  state ≠ IDLE.

## Operation
- States: IDLE, NEWG, SEND, GAP.
- Field order for a move: row, col, val (field index 0..2). For a game: a single field, diff.
- out_move_ready = !in_restart && count<DEPTH && !(in_game_valid && out_game_ready).
- out_game_ready = !in_restart && state==IDLE && count==0. A game takes priority over a move offered in the same cycle.
- IDLE: a pending game latches diff and goes to NEWG. Otherwise, if count>0 && in_core_ready, pop the head into the send register, set field=0, and go to SEND. Otherwise stay in IDLE.
- NEWG: out_new_game=1 for one cycle, then GAP (GAP_CYCLES), then SEND for diff.
- SEND: out_enter=1 for one cycle, with out_diff_cell_val = current field. Then go to GAP.
- GAP: out_enter=0 and out_diff_cell_val=00 for GAP_CYCLES cycles. Then SEND the next field if fields remain, otherwise IDLE.
- All outputs except the readies are registered. Outputs are 0 whenever not in the driving state.
- A FIFO push and pop on the same edge leave count unchanged. A push is refused when count==DEPTH (ready low); no overflow is possible.
- in_abort: FIFO emptied, state IDLE, and registered outputs 0 on the next edge. A move already partly sent is truncated. Abort overrides any handshake in the same cycle: nothing is pushed and no game is latched.
- in_restart asserted: every register clears immediately, and the readies are forced to 0. A transaction in flight is discarded.
- in_core_ready is ignored once a transaction has started.

## Timing
- Reset values: out_new_game=0, out_enter=0, out_diff_cell_val=00, out_fifo_count=0, out_busy=0. out_move_ready and out_game_ready are 0 during reset and 1 once reset is released.
- Move latency (empty FIFO, core ready): accepted at edge k, popped at edge k+1, out_enter high from edge k+2. The three enter pulses are spaced 1+GAP_CYCLES apart.
- A move occupies the core link for 3·(1+GAP_CYCLES) cycles. Back-to-back queued moves add one IDLE cycle between them, so the period is 3·(1+GAP_CYCLES)+1 cycles.
- Game: accepted at edge k, out_new_game high from edge k+1 for 1 cycle, diff enter pulse 1+GAP_CYCLES cycles later, back in IDLE 1+GAP_CYCLES cycles after that.
- out_enter and out_new_game are never high in the same cycle. out_enter is never high on two consecutive cycles.

## Test plan
- Reset: hold in_restart for 2 edges, then release → all outputs 0, both readies 1 from the first cycle after release.
- Single move row=2, col=1, val=3, GAP=1, core ready → enter high at k+2, k+4, k+6 carrying 10, 01, 11; out_busy falls at k+8.
- Back-pressure at DEPTH=2 with core ready=0: offer 3 moves → 2 accepted, count=2, out_move_ready=0. Raise core ready → the moves are sent in FIFO order, 7 cycles apart.
- Simultaneous game(diff=01) and move offer in IDLE with FIFO empty → game accepted, move refused that cycle. Sequence: new_game pulse, then the 01 enter pulse 2 cycles later, then the move accepted and sent afterwards.
- in_abort during the col field of a move with one move queued → next edge: IDLE, count=0, outputs 0, and no further enter pulses.
- Async in_restart asserted mid-gap (between edges) → outputs clear immediately. After release, the sequencer is idle and a new move is sent normally.

Source files
------------

// File: rtl/move_sequencer_if.sv
// Handshake and strobe bundle between the player front-end, move_sequencer and the game core.
interface move_sequencer_if #(
    parameter int unsigned DEPTH = 2
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             in_abort;
    logic             in_core_ready;
    logic             in_move_valid;
    logic [1:0]       in_move_row;
    logic [1:0]       in_move_col;
    logic [1:0]       in_move_val;
    logic             out_move_ready;
    logic             in_game_valid;
    logic [1:0]       in_game_diff;
    logic             out_game_ready;
    logic             out_new_game;
    logic             out_enter;
    logic [1:0]       out_diff_cell_val;
    logic [CNT_W-1:0] out_fifo_count;
    logic             out_busy;

    modport master (
        output in_abort, in_core_ready,
        output in_move_valid, in_move_row, in_move_col, in_move_val,
        output in_game_valid, in_game_diff,
        input  out_move_ready, out_game_ready,
        input  out_new_game, out_enter, out_diff_cell_val, out_fifo_count, out_busy
    );

    modport slave (
        input  in_abort, in_core_ready,
        input  in_move_valid, in_move_row, in_move_col, in_move_val,
        input  in_game_valid, in_game_diff,
        output out_move_ready, out_game_ready,
        output out_new_game, out_enter, out_diff_cell_val, out_fifo_count, out_busy
    );
endinterface

// File: rtl/move_sequencer.sv
// Queues move/new-game requests and replays them to the game core as new_game pulses and
// enter-qualified 2-bit fields separated by idle gaps.
module move_sequencer #(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic            in_clka,
    input  logic            in_restart,
    move_sequencer_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, NEWG, SEND, GAP} state_e;

    state_e             state_q, state_d;
    logic [5:0]         mem_q [DEPTH];
    logic [5:0]         mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [5:0]         send_q, send_d;
    logic [1:0]         field_q, field_d;
    logic               is_game_q, is_game_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               new_game_q, new_game_d;
    logic               enter_q, enter_d;
    logic [1:0]         dcv_q, dcv_d;
    logic               busy_q, busy_d;

    logic               game_ready_c, move_ready_c;
    logic               push, pop, game_take;
    logic [1:0]         cur_field, last_field;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Readies are combinational; a game offered with a move wins the cycle.
    assign game_ready_c = !in_restart && (state_q == IDLE) && (count_q == '0);
    assign move_ready_c = !in_restart && (count_q < CNT_W'(DEPTH)) &&
                          !(bus.in_game_valid && game_ready_c);

    assign push      = bus.in_move_valid && move_ready_c && !bus.in_abort;
    assign game_take = bus.in_game_valid && game_ready_c && !bus.in_abort;
    assign pop       = (state_q == IDLE) && !game_take && (count_q != '0) &&
                       bus.in_core_ready && !bus.in_abort;

    // A game is stored in the row slot so field 0 carries diff.
    always_comb begin
        unique case (field_q)
            2'd0:    cur_field = send_q[5:4];
            2'd1:    cur_field = send_q[3:2];
            default: cur_field = send_q[1:0];
        endcase
        last_field = is_game_q ? 2'd0 : 2'd2;
    end

    always_comb begin
        state_d   = state_q;
        mem_d     = mem_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
        send_d    = send_q;
        field_d   = field_q;
        is_game_d = is_game_q;
        gap_d     = gap_q;

        if (push) begin
            mem_d[wr_q] = {bus.in_move_row, bus.in_move_col, bus.in_move_val};
            wr_d        = ptr_inc(wr_q);
        end
        if (pop) begin
            rd_d = ptr_inc(rd_q);
        end

        unique case (state_q)
            IDLE: begin
                if (game_take) begin
                    send_d    = {bus.in_game_diff, 4'b0000};
                    is_game_d = 1'b1;
                    field_d   = 2'd0;
                    state_d   = NEWG;
                end else if (pop) begin
                    send_d    = mem_q[rd_q];
                    is_game_d = 1'b0;
                    field_d   = 2'd0;
                    state_d   = SEND;
                end
            end
            NEWG: begin
                gap_d   = '0;
                state_d = GAP;
            end
            SEND: begin
                field_d = field_q + 2'd1;
                gap_d   = '0;
                state_d = GAP;
            end
            GAP: begin
                // field_q already points past the field just sent.
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = (field_q > last_field) ? IDLE : SEND;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        new_game_d = (state_q == NEWG);
        enter_d    = (state_q == SEND);
        dcv_d      = enter_d ? cur_field : 2'b00;
        busy_d     = (state_q != IDLE);

        if (bus.in_abort) begin
            state_d    = IDLE;
            wr_d       = '0;
            rd_d       = '0;
            count_d    = '0;
            new_game_d = 1'b0;
            enter_d    = 1'b0;
            dcv_d      = 2'b00;
            busy_d     = 1'b0;
        end
    end

    always_ff @(posedge in_clka or posedge in_restart) begin
        if (in_restart) begin
            state_q    <= IDLE;
            mem_q      <= '{default: '0};
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            send_q     <= '0;
            field_q    <= '0;
            is_game_q  <= 1'b0;
            gap_q      <= '0;
            new_game_q <= 1'b0;
            enter_q    <= 1'b0;
            dcv_q      <= 2'b00;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
            send_q     <= send_d;
            field_q    <= field_d;
            is_game_q  <= is_game_d;
            gap_q      <= gap_d;
            new_game_q <= new_game_d;
            enter_q    <= enter_d;
            dcv_q      <= dcv_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.out_move_ready    = move_ready_c;
    assign bus.out_game_ready    = game_ready_c;
    assign bus.out_new_game      = new_game_q;
    assign bus.out_enter         = enter_q;
    assign bus.out_diff_cell_val = dcv_q;
    assign bus.out_fifo_count    = count_q;
    assign bus.out_busy          = busy_q;
endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer: directed stimulus queues expected strobes, a monitor checks them.
module tb_move_sequencer;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned GAP   = 1;
    localparam int          S     = 1 + GAP;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    move_sequencer_if #(.DEPTH(DEPTH)) bus ();
    move_sequencer #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
        .in_clka    (clk),
        .in_restart (rst),
        .bus        (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit       is_ng;
        logic [1:0] val;
        int       at;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic expect_strobe(input bit is_ng, input logic [1:0] val, input int at);
        exp_t e;
        e.is_ng = is_ng;
        e.val   = val;
        e.at    = at;
        exp_q.push_back(e);
    endtask

    task automatic expect_move(input logic [1:0] r, input logic [1:0] c, input logic [1:0] v,
                               input int first);
        expect_strobe(1'b0, r, first);
        expect_strobe(1'b0, c, first + S);
        expect_strobe(1'b0, v, first + 2 * S);
    endtask

    // Monitor: pops one expectation per strobe and polices the pulse rules.
    bit prev_enter = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_enter = 1'b0;
        end else begin
            check("enter_and_new_game", 32'(bus.out_enter & bus.out_new_game), 0);
            check("enter_back_to_back", 32'(prev_enter & bus.out_enter), 0);
            prev_enter = bus.out_enter;
            if (bus.out_enter || bus.out_new_game) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_strobe: enter=%0b new_game=%0b val=%0b cycle %0d",
                             bus.out_enter, bus.out_new_game, bus.out_diff_cell_val, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_kind", 32'(bus.out_new_game), 32'(e.is_ng));
                    check("strobe_value", 32'(bus.out_diff_cell_val), 32'(e.val));
                    if (e.at >= 0) check("strobe_cycle", cyc, e.at);
                end
            end
        end
    end

    task automatic to_cycle(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic offer_move(input logic [1:0] r, input logic [1:0] c, input logic [1:0] v,
                              output int k);
        k = -1;
        bus.in_move_valid = 1'b1;
        bus.in_move_row   = r;
        bus.in_move_col   = c;
        bus.in_move_val   = v;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.out_move_ready) begin
                @(posedge clk);
                #1;
                k = cyc;
                break;
            end
        end
        bus.in_move_valid = 1'b0;
        if (k < 0) begin
            checks++;
            failures++;
            $display("FAIL move_accept_timeout: got no ready expected ready within 50 cycles");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_pending", exp_q.size(), 0);
        exp_q.delete();
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int k, k2, c;
        rst = 1'b1;
        bus.in_abort      = 1'b0;
        bus.in_core_ready = 1'b1;
        bus.in_move_valid = 1'b0;
        bus.in_move_row   = 2'd0;
        bus.in_move_col   = 2'd0;
        bus.in_move_val   = 2'd0;
        bus.in_game_valid = 1'b0;
        bus.in_game_diff  = 2'd0;

        // Reset held for two edges.
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_move_ready", 32'(bus.out_move_ready), 0);
        check("rst_game_ready", 32'(bus.out_game_ready), 0);
        check("rst_enter", 32'(bus.out_enter), 0);
        check("rst_new_game", 32'(bus.out_new_game), 0);
        check("rst_count", 32'(bus.out_fifo_count), 0);
        rst = 1'b0;
        #1;
        check("rel_move_ready", 32'(bus.out_move_ready), 1);
        check("rel_game_ready", 32'(bus.out_game_ready), 1);
        @(negedge clk);
        check("rel_busy", 32'(bus.out_busy), 0);
        check("rel_dcv", 32'(bus.out_diff_cell_val), 0);
        @(posedge clk);
        #1;

        // Single move 2,1,3.
        offer_move(2'd2, 2'd1, 2'd3, k);
        expect_move(2'b10, 2'b01, 2'b11, k + 2);
        check("single_count_after_push", 32'(bus.out_fifo_count), 1);
        to_cycle(k + 1);
        check("single_count_after_pop", 32'(bus.out_fifo_count), 0);
        to_cycle(k + 7);
        check("single_busy_k7", 32'(bus.out_busy), 1);
        to_cycle(k + 8);
        check("single_busy_k8", 32'(bus.out_busy), 0);
        drain();

        // Back-pressure with the core stalled.
        bus.in_core_ready = 1'b0;
        offer_move(2'd0, 2'd3, 2'd1, k);
        offer_move(2'd3, 2'd2, 2'd2, k2);
        check("bp_second_accept_cycle", k2, k + 1);
        bus.in_move_valid = 1'b1;
        bus.in_move_row   = 2'd1;
        bus.in_move_col   = 2'd1;
        bus.in_move_val   = 2'd0;
        @(negedge clk);
        check("bp_ready_low", 32'(bus.out_move_ready), 0);
        check("bp_count_full", 32'(bus.out_fifo_count), 2);
        @(negedge clk);
        check("bp_ready_still_low", 32'(bus.out_move_ready), 0);
        bus.in_move_valid = 1'b0;
        c = cyc;
        bus.in_core_ready = 1'b1;
        expect_move(2'b00, 2'b11, 2'b01, c + 2);
        expect_move(2'b11, 2'b10, 2'b10, c + 2 + 3 * S + 1);
        drain();
        check("bp_count_empty", 32'(bus.out_fifo_count), 0);

        // Game and move offered together.
        bus.in_game_valid = 1'b1;
        bus.in_game_diff  = 2'b01;
        bus.in_move_valid = 1'b1;
        bus.in_move_row   = 2'd1;
        bus.in_move_col   = 2'd0;
        bus.in_move_val   = 2'd2;
        #1;
        check("both_game_ready", 32'(bus.out_game_ready), 1);
        check("both_move_ready", 32'(bus.out_move_ready), 0);
        @(posedge clk);
        #1;
        k = cyc;
        bus.in_game_valid = 1'b0;
        expect_strobe(1'b1, 2'b00, k + 1);
        expect_strobe(1'b0, 2'b01, k + 1 + S);
        @(negedge clk);
        check("game_then_move_ready", 32'(bus.out_move_ready), 1);
        check("game_ready_busy_low", 32'(bus.out_game_ready), 0);
        @(posedge clk);
        #1;
        bus.in_move_valid = 1'b0;
        expect_move(2'b01, 2'b00, 2'b10, k + 6);
        drain();

        // Abort while the col field is on the link, one move queued.
        offer_move(2'd2, 2'd2, 2'd1, k);
        offer_move(2'd1, 2'd3, 2'd0, k2);
        check("abort_second_accept_cycle", k2, k + 1);
        expect_strobe(1'b0, 2'b10, k + 2);
        expect_strobe(1'b0, 2'b10, k + 4);
        to_cycle(k + 4);
        check("abort_col_enter", 32'(bus.out_enter), 1);
        check("abort_queued", 32'(bus.out_fifo_count), 1);
        bus.in_abort = 1'b1;
        @(posedge clk);
        #1;
        bus.in_abort = 1'b0;
        check("abort_count", 32'(bus.out_fifo_count), 0);
        check("abort_busy", 32'(bus.out_busy), 0);
        check("abort_enter", 32'(bus.out_enter), 0);
        check("abort_dcv", 32'(bus.out_diff_cell_val), 0);
        repeat (20) @(negedge clk);
        check("abort_leftover", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk);
        #1;

        // Asynchronous restart between edges while the row pulse is out.
        offer_move(2'd3, 2'd1, 2'd2, k);
        while (cyc < k + 2) begin
            @(posedge clk);
            #1;
        end
        check("restart_pre_enter", 32'(bus.out_enter), 1);
        #2;
        rst = 1'b1;
        #1;
        check("restart_enter", 32'(bus.out_enter), 0);
        check("restart_busy", 32'(bus.out_busy), 0);
        check("restart_dcv", 32'(bus.out_diff_cell_val), 0);
        check("restart_move_ready", 32'(bus.out_move_ready), 0);
        check("restart_game_ready", 32'(bus.out_game_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("restart_rel_ready", 32'(bus.out_move_ready), 1);
        offer_move(2'd0, 2'd1, 2'd2, k);
        expect_move(2'b00, 2'b01, 2'b10, k + 2);
        drain();
        check("final_busy", 32'(bus.out_busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish by 100000ns");
        $fatal(1, "watchdog");
    end
endmodule
